// File: rtl/rr_stream_mux.sv
// N:1 valid/ready stream mux with round-robin grant and a one-entry registered output.
// Optional macro SEL_OVERRIDE_EN adds force_en/force_sel to bypass the arbiter.
module rr_stream_mux #(
  parameter int  NUM_CH = 4,
  parameter int  DATA_W = 8,
  localparam int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_ch,
  output logic                     out_valid,
  input  logic                     out_ready
`ifdef SEL_OVERRIDE_EN
  ,
  input  logic                     force_en,
  input  logic [SEL_W-1:0]         force_sel
`endif
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

  // Returns {found, index}: lowest requester above ptr, else lowest requester overall (explicit wrap).
  function automatic logic [SEL_W:0] rr_pick(input logic [NUM_CH-1:0] req, input logic [SEL_W-1:0] ptr);
    logic [SEL_W:0] r;
    r = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req[i]) r = {1'b1, SEL_W'(i)};
    end
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req[i] && (SEL_W'(i) > ptr)) r = {1'b1, SEL_W'(i)};
    end
    return r;
  endfunction

  // Forced selection only grants an in-range channel that is actually requesting.
  function automatic logic [SEL_W:0] force_pick(input logic [NUM_CH-1:0] req, input logic [SEL_W-1:0] sel);
    logic [SEL_W:0] r;
    r = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (req[i] && (sel == SEL_W'(i))) r = {1'b1, SEL_W'(i)};
    end
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] ch_data(input logic [NUM_CH*DATA_W-1:0] bus, input logic [SEL_W-1:0] sel);
    logic [DATA_W-1:0] d;
    d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel == SEL_W'(i)) d = bus[i*DATA_W +: DATA_W];
    end
    return d;
  endfunction

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;
  logic [SEL_W-1:0]   out_ch_q, out_ch_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [SEL_W-1:0]   grant_s;
  logic               found_s;
  logic               forced_s;
  logic               load_s;
  logic               accept_s;

  // Grant selection
  always_comb begin
    forced_s = 1'b0;
`ifdef SEL_OVERRIDE_EN
    if (force_en) begin
      forced_s           = 1'b1;
      {found_s, grant_s} = force_pick(in_valid, force_sel);
    end else begin
      {found_s, grant_s} = rr_pick(in_valid, ptr_q);
    end
`else
    {found_s, grant_s} = rr_pick(in_valid, ptr_q);
`endif
  end

  assign load_s   = (state_q == EMPTY) | out_ready;
  assign accept_s = load_s & found_s;

  // Handshake back to the granted channel only
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      in_ready[i] = accept_s & (grant_s == SEL_W'(i));
    end
  end

  // Next-state and output register updates
  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    out_ch_d   = out_ch_q;
    ptr_d      = ptr_q;
    case (state_q)
      EMPTY: begin
        if (accept_s) state_d = FULL;
        else          state_d = EMPTY;
      end
      FULL: begin
        if (accept_s)       state_d = FULL;
        else if (out_ready) state_d = EMPTY;
        else                state_d = FULL;
      end
      default: state_d = EMPTY;
    endcase
    if (accept_s) begin
      out_data_d = ch_data(in_data, grant_s);
      out_ch_d   = grant_s;
      ptr_d      = forced_s ? ptr_q : grant_s;
    end else begin
      out_data_d = out_data_q;
      out_ch_d   = out_ch_q;
      ptr_d      = ptr_q;
    end
  end

  // State, payload and pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      out_data_q <= '0;
      out_ch_q   <= '0;
      ptr_q      <= LAST_CH;
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      out_ch_q   <= out_ch_d;
      ptr_q      <= ptr_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_rr_stream_mux.sv
// Directed bench for rr_stream_mux: a 4-channel vector table plus a 5-channel wrap sequence.
module tb_rr_stream_mux;

  typedef struct packed {
    logic        rst;
    logic [3:0]  valid;
    logic [31:0] data;
    logic        ordy;
    logic        chk_ir;
    logic [3:0]  exp_ir;
    logic        exp_v;
    logic [1:0]  exp_ch;
    logic [7:0]  exp_d;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_valid;
  logic        out_ready;

  logic        rst5;
  logic [39:0] in_data5;
  logic [4:0]  in_valid5;
  logic [4:0]  in_ready5;
  logic [7:0]  out_data5;
  logic [2:0]  out_ch5;
  logic        out_valid5;
  logic        out_ready5;

`ifdef SEL_OVERRIDE_EN
  logic        force_en;
  logic [1:0]  force_sel;
`endif

  int checks = 0;
  int errors = 0;
  vec_t vecs[22];

  always #5 clk = ~clk;

  rr_stream_mux #(.NUM_CH(4), .DATA_W(8)) dut4 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
`ifdef SEL_OVERRIDE_EN
    , .force_en(force_en), .force_sel(force_sel)
`endif
  );

  rr_stream_mux #(.NUM_CH(5), .DATA_W(8)) dut5 (
    .clk(clk), .rst(rst5), .in_data(in_data5), .in_valid(in_valid5), .in_ready(in_ready5),
    .out_data(out_data5), .out_ch(out_ch5), .out_valid(out_valid5), .out_ready(out_ready5)
`ifdef SEL_OVERRIDE_EN
    , .force_en(1'b0), .force_sel(3'd0)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One cycle: drive inputs, check combinational in_ready, then check registered outputs after the edge.
  task automatic cyc(input string tag, input vec_t v);
    rst       = v.rst;
    in_valid  = v.valid;
    in_data   = v.data;
    out_ready = v.ordy;
    #1;
    if (v.chk_ir) chk({tag, " in_ready"}, {28'd0, in_ready}, {28'd0, v.exp_ir});
    @(posedge clk);
    #1;
    chk({tag, " out_valid"}, {31'd0, out_valid}, {31'd0, v.exp_v});
    chk({tag, " out_ch"}, {30'd0, out_ch}, {30'd0, v.exp_ch});
    chk({tag, " out_data"}, {24'd0, out_data}, {24'd0, v.exp_d});
  endtask

  initial begin
    //            rst   valid  data          ordy  chk   exp_ir v     ch     data
    // fairness, all four channels
    vecs[0]  = '{1'b0, 4'hF, 32'hA3A2A1A0, 1'b1, 1'b1, 4'h1, 1'b1, 2'd0, 8'hA0};
    vecs[1]  = '{1'b0, 4'hF, 32'hA3A2A1A0, 1'b1, 1'b1, 4'h2, 1'b1, 2'd1, 8'hA1};
    vecs[2]  = '{1'b0, 4'hF, 32'hA3A2A1A0, 1'b1, 1'b1, 4'h4, 1'b1, 2'd2, 8'hA2};
    vecs[3]  = '{1'b0, 4'hF, 32'hA3A2A1A0, 1'b1, 1'b1, 4'h8, 1'b1, 2'd3, 8'hA3};
    vecs[4]  = '{1'b0, 4'hF, 32'hA3A2A1A0, 1'b1, 1'b1, 4'h1, 1'b1, 2'd0, 8'hA0};
    // reach ch2 = 55, then stall five cycles
    vecs[5]  = '{1'b0, 4'hF, 32'hA355A1A0, 1'b1, 1'b1, 4'h2, 1'b1, 2'd1, 8'hA1};
    vecs[6]  = '{1'b0, 4'hF, 32'hA355A1A0, 1'b1, 1'b1, 4'h4, 1'b1, 2'd2, 8'h55};
    vecs[7]  = '{1'b0, 4'hF, 32'hA355A1A0, 1'b0, 1'b1, 4'h0, 1'b1, 2'd2, 8'h55};
    vecs[8]  = '{1'b0, 4'hF, 32'hA355A1A0, 1'b0, 1'b1, 4'h0, 1'b1, 2'd2, 8'h55};
    vecs[9]  = '{1'b0, 4'hF, 32'hA355A1A0, 1'b0, 1'b1, 4'h0, 1'b1, 2'd2, 8'h55};
    vecs[10] = '{1'b0, 4'hF, 32'hA355A1A0, 1'b0, 1'b1, 4'h0, 1'b1, 2'd2, 8'h55};
    vecs[11] = '{1'b0, 4'hF, 32'hA355A1A0, 1'b0, 1'b1, 4'h0, 1'b1, 2'd2, 8'h55};
    vecs[12] = '{1'b0, 4'hF, 32'hA355A1A0, 1'b1, 1'b1, 4'h8, 1'b1, 2'd3, 8'hA3};
    // single requester ch1, then it drops
    vecs[13] = '{1'b0, 4'h2, 32'hA3553CA0, 1'b1, 1'b1, 4'h2, 1'b1, 2'd1, 8'h3C};
    vecs[14] = '{1'b0, 4'h2, 32'hA3553CA0, 1'b1, 1'b1, 4'h2, 1'b1, 2'd1, 8'h3C};
    vecs[15] = '{1'b0, 4'h2, 32'hA3553CA0, 1'b1, 1'b1, 4'h2, 1'b1, 2'd1, 8'h3C};
    vecs[16] = '{1'b0, 4'h0, 32'hA3553CA0, 1'b1, 1'b1, 4'h0, 1'b0, 2'd1, 8'h3C};
    vecs[17] = '{1'b0, 4'h0, 32'hA3553CA0, 1'b1, 1'b1, 4'h0, 1'b0, 2'd1, 8'h3C};
    // empty register accepts even with out_ready low; then it stalls
    vecs[18] = '{1'b0, 4'h4, 32'hA3553CA0, 1'b0, 1'b1, 4'h4, 1'b1, 2'd2, 8'h55};
    vecs[19] = '{1'b0, 4'hF, 32'hA3553CA0, 1'b0, 1'b1, 4'h0, 1'b1, 2'd2, 8'h55};
    // reset while holding ch2, first beat afterwards from ch0
    vecs[20] = '{1'b1, 4'hF, 32'hA3A2A1A0, 1'b1, 1'b0, 4'h0, 1'b0, 2'd0, 8'h00};
    vecs[21] = '{1'b0, 4'hF, 32'hA3A2A1A0, 1'b1, 1'b1, 4'h1, 1'b1, 2'd0, 8'hA0};

    rst = 1'b1; in_valid = 4'h0; in_data = 32'd0; out_ready = 1'b1;
    rst5 = 1'b1; in_valid5 = 5'h0; in_data5 = 40'd0; out_ready5 = 1'b1;
`ifdef SEL_OVERRIDE_EN
    force_en = 1'b0; force_sel = 2'd0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset out_ch", {30'd0, out_ch}, 32'd0);
    chk("reset out_data", {24'd0, out_data}, 32'd0);

    for (int i = 0; i < 22; i++) cyc($sformatf("v%0d", i), vecs[i]);

`ifdef SEL_OVERRIDE_EN
    // forced ch2 beats, then forced idle channel drains, then round-robin from ptr+1 (ptr still 0)
    force_en = 1'b1; force_sel = 2'd2;
    for (int i = 0; i < 3; i++)
      cyc($sformatf("force2_%0d", i), '{1'b0, 4'hF, 32'hA3A2A1A0, 1'b1, 1'b1, 4'h4, 1'b1, 2'd2, 8'hA2});
    force_sel = 2'd3;
    cyc("force3", '{1'b0, 4'h7, 32'hA3A2A1A0, 1'b1, 1'b1, 4'h0, 1'b0, 2'd2, 8'hA2});
    force_en = 1'b0;
    cyc("unforce", '{1'b0, 4'hF, 32'hA3A2A1A0, 1'b1, 1'b1, 4'h2, 1'b1, 2'd1, 8'hA1});
`endif

    // five-channel wrap: grant order 0,1,2,3,4,0,... and never an out-of-range channel
    @(posedge clk);
    #1;
    rst5 = 1'b0;
    in_valid5 = 5'h1F;
    in_data5 = 40'hB4B3B2B1B0;
    out_ready5 = 1'b1;
    for (int k = 0; k < 12; k++) begin
      logic [7:0] exp_d5;
      @(posedge clk);
      #1;
      exp_d5 = 8'hB0 + 8'(k % 5);
      chk($sformatf("wrap5 %0d out_valid", k), {31'd0, out_valid5}, 32'd1);
      chk($sformatf("wrap5 %0d out_ch", k), {29'd0, out_ch5}, 32'(k % 5));
      chk($sformatf("wrap5 %0d out_data", k), {24'd0, out_data5}, {24'd0, exp_d5});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
